// File: rtl/calc_uart_pkg.sv
// Shared types and constants for the calculator result UART path.
// ASCII encoding helpers live here so the sequencer stays a pure datapath.
package calc_uart_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 434;

  localparam logic [7:0] ASCII_BANG = 8'h21;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_A    = 8'h41;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, NEXT} state_t;

  typedef struct packed {
    logic [15:0] data;
    logic        ovf;
  } result_t;

  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    logic [7:0] c;
    c = (nib < 4'd10) ? ASCII_ZERO + {4'd0, nib}
                      : ASCII_A + ({4'd0, nib} - 8'd10);
    return c;
  endfunction

  // Character idx of the message for result r: 4 hex digits, optional '!', CR, LF.
  function automatic logic [7:0] msg_char(input result_t r, input logic [2:0] idx);
    logic [7:0] c;
    case (idx)
      3'd0:    c = hex_ascii(r.data[15:12]);
      3'd1:    c = hex_ascii(r.data[11:8]);
      3'd2:    c = hex_ascii(r.data[7:4]);
      3'd3:    c = hex_ascii(r.data[3:0]);
      3'd4:    c = r.ovf ? ASCII_BANG : ASCII_CR;
      3'd5:    c = r.ovf ? ASCII_CR : ASCII_LF;
      default: c = ASCII_LF;
    endcase
    return c;
  endfunction

  function automatic logic [2:0] last_idx(input result_t r);
    return r.ovf ? 3'd6 : 3'd5;
  endfunction

endpackage

// File: rtl/result_ascii_tx_if.sv
// Result-in / serial-out signal bundle for result_ascii_tx.
interface result_ascii_tx_if;
  logic        start;
  logic [15:0] data;
  logic        overflow;
  logic        tx;
  logic        busy;

  modport master (output start, data, overflow, input tx, busy);
  modport slave  (input start, data, overflow, output tx, busy);
endinterface

// File: rtl/uart_byte_tx.sv
// 8N1 byte serializer with a valid/ready byte handshake.
// ready is offered in IDLE and in NEXT (last stop-bit cycle) so frames can abut.
module uart_byte_tx
  import calc_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] tx_byte,
  input  logic       valid,
  output logic       ready,
  output logic       active,
  output logic       tx
);

  localparam int TW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] T_STOP = TW'(CLKS_PER_BIT - 2);

  state_t          state, state_n;
  logic [TW-1:0]   tmr, tmr_n;
  logic [2:0]      bit_idx, bit_idx_n;
  logic [7:0]      shreg, shreg_n;
  logic            tx_q, tx_n;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      tmr     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state   <= state_n;
      tmr     <= tmr_n;
      bit_idx <= bit_idx_n;
      shreg   <= shreg_n;
      tx_q    <= tx_n;
    end
  end

  always_comb begin
    state_n   = state;
    tmr_n     = tmr;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    tx_n      = tx_q;
    ready     = 1'b0;
    case (state)
      IDLE, NEXT: begin
        ready = 1'b1;
        tmr_n = '0;
        tx_n  = 1'b1;
        if (valid) begin
          state_n = START;
          shreg_n = tx_byte;
          tx_n    = 1'b0;
        end else begin
          state_n = IDLE;
        end
      end
      START: begin
        if (tmr == T_LAST) begin
          tmr_n     = '0;
          state_n   = DATA;
          bit_idx_n = '0;
          tx_n      = shreg[0];
        end else begin
          tmr_n = tmr + 1'b1;
        end
      end
      DATA: begin
        if (tmr == T_LAST) begin
          tmr_n = '0;
          if (bit_idx == 3'd7) begin
            state_n   = STOP;
            bit_idx_n = '0;
            tx_n      = 1'b1;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
            shreg_n   = {1'b0, shreg[7:1]};
            tx_n      = shreg[1];
          end
        end else begin
          tmr_n = tmr + 1'b1;
        end
      end
      STOP: begin
        // The stop bit's final cycle is spent in NEXT, where the follow-on byte is taken.
        tmr_n = tmr + 1'b1;
        if (tmr == T_STOP) state_n = NEXT;
      end
      default: state_n = IDLE;
    endcase
  end

  assign tx     = tx_q;
  assign active = (state != IDLE);

endmodule

// File: rtl/result_ascii_tx.sv
// Turns each calculator result into "HHHH[!]\r\n" on a UART line.
// Holds the current message, its character index, and a one-deep pending slot.
module result_ascii_tx
  import calc_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic              clock,
  input  logic              reset,
  result_ascii_tx_if.slave  bus
);

  result_t     cur, pend, incoming;
  logic        pend_vld;
  logic        msg_active;
  logic [2:0]  char_idx;

  logic [7:0]  byte_val;
  logic        byte_valid, byte_ready, tx_active, tx_w;
  logic        launch_pend, launch_new, fire, store_pend;

  assign incoming = {bus.data, bus.overflow};

  always_comb begin
    launch_pend = !msg_active && pend_vld;
    launch_new  = !msg_active && !pend_vld && !tx_active && bus.start;
    byte_valid  = msg_active || launch_pend || launch_new;
    byte_val    = msg_active  ? msg_char(cur, char_idx) :
                  launch_pend ? msg_char(pend, 3'd0)    :
                                msg_char(incoming, 3'd0);
    fire        = byte_valid && byte_ready;
    // Any start not launched straight from idle lands in the pending slot.
    store_pend  = bus.start && !(fire && launch_new);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cur        <= '0;
      pend       <= '0;
      pend_vld   <= 1'b0;
      msg_active <= 1'b0;
      char_idx   <= '0;
    end else begin
      if (fire) begin
        if (msg_active) begin
          if (char_idx == last_idx(cur)) begin
            msg_active <= 1'b0;
            char_idx   <= '0;
          end else begin
            char_idx <= char_idx + 3'd1;
          end
        end else begin
          msg_active <= 1'b1;
          char_idx   <= 3'd1;
          cur        <= launch_pend ? pend : incoming;
        end
      end
      if (store_pend) begin
        pend     <= incoming;
        pend_vld <= 1'b1;
      end else if (fire && launch_pend) begin
        pend_vld <= 1'b0;
      end
    end
  end

  uart_byte_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte_tx (
    .clock   (clock),
    .reset   (reset),
    .tx_byte (byte_val),
    .valid   (byte_valid),
    .ready   (byte_ready),
    .active  (tx_active),
    .tx      (tx_w)
  );

  assign bus.tx   = tx_w;
  assign bus.busy = tx_active || pend_vld || msg_active;

endmodule

// File: tb/tb_result_ascii_tx.sv
// Bench for result_ascii_tx: line-waveform model, UART decoder, directed scenarios.
module tb_result_ascii_tx;

  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;

  typedef logic [7:0] bq_t[$];

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  result_ascii_tx_if bus();

  result_ascii_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int errs = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: expected tx level per cycle, built as a concatenation of 8N1 frames.
  logic        line_q[$];
  logic        pend_v = 1'b0;
  logic [15:0] pend_d;
  logic        pend_o;

  task automatic push_msg(input logic [15:0] d, input logic o);
    logic [7:0] ch[$];
    logic [7:0] n;
    ch = {};
    for (int i = 3; i >= 0; i--) begin
      n = {4'h0, d[i*4 +: 4]};
      ch.push_back((n < 8'd10) ? 8'h30 + n : 8'h37 + n);
    end
    if (o) ch.push_back(8'h21);
    ch.push_back(8'h0D);
    ch.push_back(8'h0A);
    for (int k = 0; k < ch.size(); k++) begin
      repeat (CPB) line_q.push_back(1'b0);
      for (int b = 0; b < 8; b++) repeat (CPB) line_q.push_back(ch[k][b]);
      repeat (CPB) line_q.push_back(1'b1);
    end
  endtask

  initial begin
    bit was_idle, consumed;
    forever begin
      @(posedge clock or posedge reset);
      if (reset) begin
        line_q.delete();
        pend_v = 1'b0;
      end else begin
        was_idle = (line_q.size() == 0);
        if (!was_idle) void'(line_q.pop_front());
        consumed = 1'b0;
        if (line_q.size() == 0 && pend_v) begin
          push_msg(pend_d, pend_o);
          pend_v = 1'b0;
        end else if (was_idle && bus.start) begin
          push_msg(bus.data, bus.overflow);
          consumed = 1'b1;
        end
        if (bus.start && !consumed) begin
          pend_v = 1'b1;
          pend_d = bus.data;
          pend_o = bus.overflow;
        end
      end
    end
  end

  // Compare against the model every cycle and decode bytes off the line.
  int         cyc = 0;
  logic       prev_tx = 1'b1;
  bit         rx_act = 1'b0;
  int         rx_cnt, rx_t0, j;
  logic [7:0] rx_sh;
  logic [7:0] rx_q[$];
  int         rx_t[$];

  initial begin
    forever begin
      @(negedge clock);
      cyc++;
      chk("tx_vs_model", 32'(bus.tx), 32'((line_q.size() != 0) ? line_q[0] : 1'b1));
      chk("busy_vs_model", 32'(bus.busy), 32'(line_q.size() != 0 || pend_v));
      if (reset) begin
        rx_act  = 1'b0;
        prev_tx = 1'b1;
      end else begin
        if (!rx_act) begin
          if (!bus.tx && prev_tx) begin
            rx_act = 1'b1;
            rx_cnt = 0;
            rx_t0  = cyc;
          end
        end else begin
          rx_cnt++;
          if (rx_cnt % CPB == CPB / 2) begin
            j = rx_cnt / CPB;
            if (j >= 1 && j <= 8) rx_sh[j-1] = bus.tx;
            else if (j == 9) begin
              chk("stop_bit", 32'(bus.tx), 32'd1);
              rx_q.push_back(rx_sh);
              rx_t.push_back(rx_t0);
              rx_act = 1'b0;
            end
          end
        end
        prev_tx = bus.tx;
      end
    end
  end

  task automatic send(input logic [15:0] d, input logic o);
    @(negedge clock);
    bus.start = 1'b1;
    bus.data = d;
    bus.overflow = o;
    @(negedge clock);
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(input string name, output int n);
    n = 0;
    while (bus.busy && n < 5000) begin
      n++;
      @(negedge clock);
    end
    if (n >= 5000) chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic expect_bytes(input string name, input bq_t e);
    chk({name, "_count"}, rx_q.size(), e.size());
    for (int i = 0; i < e.size(); i++)
      chk($sformatf("%s_byte%0d", name, i), (i < rx_q.size()) ? 32'(rx_q[i]) : 32'hFFFF_FFFF, 32'(e[i]));
    rx_q.delete();
  endtask

  task automatic check_gaps(input string name);
    for (int i = 1; i < rx_t.size(); i++)
      chk($sformatf("%s_gap%0d", name, i), rx_t[i] - rx_t[i-1], FRAME);
    rx_t.delete();
  endtask

  initial begin
    int n, nb, n0;
    bq_t e;
    bus.start = 1'b0;
    bus.data = '0;
    bus.overflow = 1'b0;
    repeat (3) @(negedge clock);
    chk("reset_tx", 32'(bus.tx), 32'd1);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    reset = 1'b0;

    send(16'h1A2F, 1'b0);
    wait_idle("t1", n);
    chk("t1_busy_cycles", n, 240);
    repeat (5) @(negedge clock);
    e = {8'h31, 8'h41, 8'h32, 8'h46, 8'h0D, 8'h0A};
    expect_bytes("t1", e);
    check_gaps("t1");

    send(16'hFFFF, 1'b1);
    wait_idle("t2", n);
    chk("t2_busy_cycles", n, 280);
    repeat (5) @(negedge clock);
    e = {8'h46, 8'h46, 8'h46, 8'h46, 8'h21, 8'h0D, 8'h0A};
    expect_bytes("t2", e);
    check_gaps("t2");

    send(16'h0001, 1'b0);
    repeat (48) @(negedge clock);
    send(16'h0002, 1'b0);
    repeat (48) @(negedge clock);
    send(16'h0003, 1'b0);
    wait_idle("t3", n);
    repeat (5) @(negedge clock);
    e = {8'h30, 8'h30, 8'h30, 8'h31, 8'h0D, 8'h0A, 8'h30, 8'h30, 8'h30, 8'h33, 8'h0D, 8'h0A};
    expect_bytes("t3", e);
    check_gaps("t3");

    // Char 3 of 0x1234 is '3' (0x33); its data bit 2 (a 0) spans cycles 92..95.
    send(16'h1234, 1'b0);
    repeat (93) @(negedge clock);
    chk("t4_tx_in_data", 32'(bus.tx), 32'd0);
    #1 reset = 1'b1;
    #1;
    chk("t4_tx_async", 32'(bus.tx), 32'd1);
    chk("t4_busy_async", 32'(bus.busy), 32'd0);
    e = {8'h31, 8'h32};
    expect_bytes("t4", e);
    rx_t.delete();
    repeat (3) @(negedge clock);
    reset = 1'b0;
    nb = 0;
    repeat (200) begin
      @(negedge clock);
      if (bus.busy) nb++;
    end
    chk("t4_busy_after", nb, 0);
    chk("t4_no_bytes", rx_q.size(), 0);

    @(negedge clock);
    reset = 1'b1;
    bus.start = 1'b1;
    bus.data = 16'h5555;
    @(negedge clock);
    bus.start = 1'b0;
    reset = 1'b0;
    nb = 0;
    n0 = 0;
    repeat (100) begin
      @(negedge clock);
      if (bus.busy) nb++;
      if (!bus.tx) n0++;
    end
    chk("t5_busy", nb, 0);
    chk("t5_tx_low", n0, 0);
    chk("t5_no_bytes", rx_q.size(), 0);

    send(16'h0000, 1'b0);
    wait_idle("t6", n);
    chk("t6_busy_cycles", n, 240);
    repeat (5) @(negedge clock);
    e = {8'h30, 8'h30, 8'h30, 8'h30, 8'h0D, 8'h0A};
    expect_bytes("t6", e);
    check_gaps("t6");

    repeat (5) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/result_ascii_tx.md
RESULT_ASCII_TX -- requirements
Module: result_ascii_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, meaning clock cycles per UART bit (50 MHz / 115200 baud).
REQ-002 SHALL have port clock, input, 1 bit: the single clock; all state on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: one-cycle pulse meaning a new calculator result is valid.
REQ-005 SHALL have port data, input, 16 bits: result value, sampled only on start.
REQ-006 SHALL have port overflow, input, 1 bit: overflow flag, sampled with data.
REQ-007 SHALL have port tx, output, 1 bit: UART serial line, idle high.
REQ-008 SHALL have port busy, output, 1 bit: high while a message is being serialized or is pending.

Function
REQ-009 SHALL transmit each accepted result as an ASCII message of 4 uppercase hex digits, MSB nibble first.
REQ-010 SHALL insert '!' (0x21) after the 4 digits when the sampled overflow is 1.
REQ-011 SHALL end every message with CR (0x0D) then LF (0x0A), giving 6 characters normally or 7 with overflow.
REQ-012 SHALL map nibbles 0-9 to 0x30-0x39 and A-F to 0x41-0x46.
REQ-013 SHALL frame each character as 8N1: start bit 0, 8 data bits LSB first, stop bit 1, each bit exactly CLKS_PER_BIT cycles.
REQ-014 SHALL send characters back-to-back, with the next start bit immediately after the previous stop bit.
REQ-015 SHALL use the states IDLE, START, DATA, STOP and NEXT: IDLE->START on accept; START->DATA, DATA->STOP after bit 7, and STOP->NEXT, each after CLKS_PER_BIT cycles; NEXT->START if characters remain; otherwise NEXT->START if pending is valid, else NEXT->IDLE.
REQ-016 SHALL, on start sampled high in IDLE at edge N, latch data and overflow and drive tx low and busy high from edge N+1.
REQ-017 SHALL, on start while not IDLE, store data and overflow in a one-deep pending slot, overwriting any earlier pending value.
REQ-018 SHALL, when a message ends with pending valid, launch the pending message as the next frame with no idle bit, then clear pending.
REQ-019 SHALL never alter the character being serialized when start arrives mid-frame.
REQ-020 SHALL drive busy low only in IDLE with pending empty; busy low occurs the cycle after the final stop bit completes.
REQ-021 SHALL keep tx at 1 whenever in IDLE.
REQ-022 SHALL count at most CLKS_PER_BIT-1 in the bit-timer, and at most 7 in the bit index, with no wrap glitch on tx.

Reset
REQ-023 SHALL, on reset assertion, immediately and asynchronously set tx=1, busy=0, state IDLE, pending cleared, and all counters 0.
REQ-024 SHALL abandon a message in progress when reset is asserted mid-frame; no partial character resumes after release.
REQ-025 SHALL give reset priority over start when both are high; the start is lost.

Structure
REQ-026 SHALL place the state enum, the ASCII constants (0x21, 0x0D, 0x0A, 0x30, 0x41) and the default CLKS_PER_BIT in shared package calc_uart_pkg.
REQ-027 SHALL instantiate one sub-module, uart_byte_tx, that owns the bit timer and the 8N1 shifter (byte in, valid/ready handshake, tx out); message sequencing and the pending slot stay in result_ascii_tx.

Verification (CLKS_PER_BIT=4)
REQ-028 SHALL check: start with data=16'h1A2F, overflow=0 -> bytes 0x31,0x41,0x32,0x46,0x0D,0x0A decoded; busy high for exactly 240 cycles.
REQ-029 SHALL check: start with data=16'hFFFF, overflow=1 -> bytes 0x46,0x46,0x46,0x46,0x21,0x0D,0x0A; busy high for exactly 280 cycles.
REQ-030 SHALL check: start 16'h0001, then during char 2 start 16'h0002, then start 16'h0003 -> message "0001\r\n" immediately followed by "0003\r\n"; 0x0002 never sent.
REQ-031 SHALL check: reset asserted in DATA state of char 3 -> tx=1 and busy=0 in the same cycle; no bytes appear after reset release until a new start.
REQ-032 SHALL check: start and reset high in the same cycle -> tx stays 1, busy stays 0, and nothing is transmitted.
REQ-033 SHALL check: start 16'h0000 -> "0000\r\n"; each bit period measured as exactly 4 cycles and each stop bit sampled as 1.
